// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Walks every 2^N_IN input vector of a combinational block, holds each one
//   for HOLD cycles, samples the 1-bit response on the last hold cycle and
//   compares it with the EXPECT truth table (bit i = response for vector i).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; results of the last sweep/abort retained
//   RUN   | driving vec_out_o = idx, sampling on the last hold cycle
//   DONE  | sweep complete; done/pass valid until start, abort or reset
//
// Ports
//   clk_i             rising-edge clock
//   rst_n_i           synchronous active-low reset
//   start_i           begin a sweep (honoured in IDLE/DONE only)
//   abort_i           end the sweep, back to IDLE (wins over start_i)
//   vec_out_o         vector driven to the block under test
//   dut_resp_i        response of the block under test
//   busy_o            high while sweeping
//   done_o            high in DONE
//   pass_o            high in DONE when no mismatch was seen
//   err_count_o       mismatches counted in the last sweep
//   first_err_idx_o   vector index of the first mismatch
//   first_err_valid_o at least one mismatch recorded
module truth_table_sweeper #(
  parameter int                    N_IN   = 3,
  parameter int                    HOLD   = 3,
  parameter logic [(1<<N_IN)-1:0]  EXPECT = 8'h26
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [N_IN-1:0]   vec_out_o,
  input  logic              dut_resp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [N_IN:0]     err_count_o,
  output logic [N_IN-1:0]   first_err_idx_o,
  output logic              first_err_valid_o
);

  // HOLD=1 still gets a 1-bit counter that simply never advances.
  localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   fidx_q, fidx_d;
  logic              fval_q, fval_d;

  logic              sample;
  logic              mismatch;

  assign sample   = (hold_q == HOLD_LAST);
  assign mismatch = (dut_resp_i != EXPECT[idx_q]);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fval_q  <= fval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fval_d  = fval_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (start_i) begin
          state_d = S_RUN;
          idx_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          fidx_d  = '0;
          fval_d  = 1'b0;
        end
      end

      S_RUN: begin
        if (abort_i) begin
          // Error results are left untouched so they can be inspected.
          state_d = S_IDLE;
          idx_d   = '0;
          hold_d  = '0;
        end else if (!sample) begin
          hold_d = hold_q + HW'(1);
        end else begin
          if (mismatch) begin
            err_d = err_q + (N_IN+1)'(1);
            if (!fval_q) begin
              fidx_d = idx_q;
              fval_d = 1'b1;
            end
          end
          hold_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + N_IN'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  assign vec_out_o         = (state_q == S_RUN) ? idx_q : '0;
  assign busy_o            = (state_q == S_RUN);
  assign done_o            = (state_q == S_DONE);
  assign pass_o            = (state_q == S_DONE) && (err_q == '0);
  assign err_count_o       = err_q;
  assign first_err_idx_o   = fidx_q;
  assign first_err_valid_o = fval_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (N_IN=3, HOLD=3, EXPECT=8'h26)
  logic       rst_n_a, start_a, abort_a, dut_resp_a;
  logic [2:0] vec_a;
  logic       busy_a, done_a, pass_a;
  logic [3:0] err_a;
  logic [2:0] fidx_a;
  logic       fval_a;

  // Instance B: 4-input AND, HOLD=1
  logic       rst_n_b, start_b, abort_b, dut_resp_b;
  logic [3:0] vec_b;
  logic       busy_b, done_b, pass_b;
  logic [4:0] err_b;
  logic [3:0] fidx_b;
  logic       fval_b;

  int tests = 0;
  int fails = 0;
  int mode_a = 0;   // 0 correct, 1 stuck-0, 2 inverted, 3 stuck-1, 4 random table
  int mode_b = 0;   // 0 correct AND, 1 tied 1
  logic [7:0] rand_tbl = 8'h00;

  truth_table_sweeper u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n_a), .start_i(start_a), .abort_i(abort_a),
    .vec_out_o(vec_a), .dut_resp_i(dut_resp_a), .busy_o(busy_a),
    .done_o(done_a), .pass_o(pass_a), .err_count_o(err_a),
    .first_err_idx_o(fidx_a), .first_err_valid_o(fval_a)
  );

  truth_table_sweeper #(.N_IN(4), .HOLD(1), .EXPECT(16'h8000)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n_b), .start_i(start_b), .abort_i(abort_b),
    .vec_out_o(vec_b), .dut_resp_i(dut_resp_b), .busy_o(busy_b),
    .done_o(done_b), .pass_o(pass_b), .err_count_o(err_b),
    .first_err_idx_o(fidx_b), .first_err_valid_o(fval_b)
  );

  // Reference gate function A = (Y|Z)&(Z|~X)&(~Y|~Z), vector = {X,Y,Z}
  function automatic logic model_a(input logic [2:0] v);
    logic x, y, z;
    {x, y, z} = v;
    return (y | z) & (z | ~x) & (~y | ~z);
  endfunction

  function automatic logic resp_a(input int mode, input logic [2:0] v);
    case (mode)
      0:       return model_a(v);
      1:       return 1'b0;
      2:       return ~model_a(v);
      3:       return 1'b1;
      default: return rand_tbl[v];
    endcase
  endfunction

  always_comb begin
    dut_resp_a = resp_a(mode_a, vec_a);
    case (mode_a)
      4:       dut_resp_a = rand_tbl[vec_a];
      default: ;
    endcase
  end

  always_comb begin
    dut_resp_b = (mode_b == 1) ? 1'b1 : &vec_b;
  end

  // Full or aborted sweep on instance A. start_at / abort_at are RUN-cycle
  // numbers (-1 = never) at which start_a / abort_a are pulsed.
  task automatic run_a(input string name, input int start_at, input int abort_at);
    int   ex_err   = 0;
    int   ex_first = 0;
    logic ex_val   = 1'b0;
    int   lim;
    bit   aborted  = 1'b0;
    lim = (abort_at >= 0) ? abort_at : 24;
    for (int v = 0; v < 8; v++) begin
      if ((v * 3 + 2) < lim && resp_a(mode_a, 3'(v)) !== model_a(3'(v))) begin
        ex_err++;
        if (!ex_val) begin
          ex_val   = 1'b1;
          ex_first = v;
        end
      end
    end
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    for (int c = 0; c < 24; c++) begin
      tests++;
      if (busy_a !== 1'b1 || vec_a !== 3'(c / 3)) begin
        fails++;
        $display("FAIL %s cycle %0d: busy=%b vec=%0d, expected busy=1 vec=%0d",
                 name, c, busy_a, vec_a, c / 3);
      end
      start_a = (c == start_at);
      abort_a = (c == abort_at);
      @(negedge clk);
      start_a = 1'b0;
      abort_a = 1'b0;
      if (c == abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      tests++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 || vec_a !== 3'd0) begin
        fails++;
        $display("FAIL %s abort idle: busy=%b done=%b pass=%b vec=%0d, expected all 0",
                 name, busy_a, done_a, pass_a, vec_a);
      end
      tests++;
      if (err_a !== 4'(ex_err) || fval_a !== ex_val || fidx_a !== 3'(ex_first)) begin
        fails++;
        $display("FAIL %s abort results: err=%0d fval=%b fidx=%0d, expected err=%0d fval=%b fidx=%0d",
                 name, err_a, fval_a, fidx_a, ex_err, ex_val, ex_first);
      end
    end else begin
      tests++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || vec_a !== 3'd0 || pass_a !== (ex_err == 0)) begin
        fails++;
        $display("FAIL %s done: done=%b busy=%b vec=%0d pass=%b, expected done=1 busy=0 vec=0 pass=%b",
                 name, done_a, busy_a, vec_a, pass_a, ex_err == 0);
      end
      tests++;
      if (err_a !== 4'(ex_err) || fval_a !== ex_val || fidx_a !== 3'(ex_first)) begin
        fails++;
        $display("FAIL %s results: err=%0d fval=%b fidx=%0d, expected err=%0d fval=%b fidx=%0d",
                 name, err_a, fval_a, fidx_a, ex_err, ex_val, ex_first);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (done_a !== 1'b1 || err_a !== 4'(ex_err) || pass_a !== (ex_err == 0)) begin
        fails++;
        $display("FAIL %s hold in done: done=%b err=%0d pass=%b, expected done=1 err=%0d pass=%b",
                 name, done_a, err_a, pass_a, ex_err, ex_err == 0);
      end
    end
  endtask

  task automatic run_b(input string name);
    int   ex_err   = 0;
    int   ex_first = 0;
    logic ex_val   = 1'b0;
    for (int v = 0; v < 16; v++) begin
      if (((mode_b == 1) ? 1'b1 : (v == 15)) != (v == 15)) begin
        ex_err++;
        if (!ex_val) begin
          ex_val   = 1'b1;
          ex_first = v;
        end
      end
    end
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tests++;
      if (busy_b !== 1'b1 || vec_b !== 4'(c)) begin
        fails++;
        $display("FAIL %s cycle %0d: busy=%b vec=%0d, expected busy=1 vec=%0d",
                 name, c, busy_b, vec_b, c);
      end
      @(negedge clk);
    end
    tests++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || pass_b !== (ex_err == 0)) begin
      fails++;
      $display("FAIL %s done: done=%b busy=%b pass=%b, expected done=1 busy=0 pass=%b",
               name, done_b, busy_b, pass_b, ex_err == 0);
    end
    tests++;
    if (err_b !== 5'(ex_err) || fval_b !== ex_val || fidx_b !== 4'(ex_first)) begin
      fails++;
      $display("FAIL %s results: err=%0d fval=%b fidx=%0d, expected err=%0d fval=%b fidx=%0d",
               name, err_b, fval_b, fidx_b, ex_err, ex_val, ex_first);
    end
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);
    tests++;
    if ({vec_a, busy_a, done_a, pass_a, err_a, fidx_a, fval_a} !== '0) begin
      fails++;
      $display("FAIL reset_a: vec=%0d busy=%b done=%b pass=%b err=%0d fidx=%0d fval=%b, expected all 0",
               vec_a, busy_a, done_a, pass_a, err_a, fidx_a, fval_a);
    end
    tests++;
    if ({vec_b, busy_b, done_b, pass_b, err_b, fidx_b, fval_b} !== '0) begin
      fails++;
      $display("FAIL reset_b: vec=%0d busy=%b done=%b pass=%b err=%0d fidx=%0d fval=%b, expected all 0",
               vec_b, busy_b, done_b, pass_b, err_b, fidx_b, fval_b);
    end
  endtask

  task automatic test_faults();
    mode_a = 0; run_a("correct", -1, -1);
    mode_a = 1; run_a("stuck0", -1, -1);
    mode_a = 3; run_a("stuck1", -1, -1);
    mode_a = 2; run_a("inverted", -1, -1);
    mode_a = 0; run_a("restart_correct", -1, -1);
  endtask

  task automatic test_random();
    mode_a = 4;
    for (int i = 0; i < 4; i++) begin
      rand_tbl = 8'($urandom);
      run_a($sformatf("random%0d", i), -1, -1);
    end
  endtask

  task automatic test_abort();
    mode_a = 1;
    run_a("abort_vec4", 5, 12);
  endtask

  task automatic test_start_abort_same();
    @(negedge clk);
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    tests++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      fails++;
      $display("FAIL start_abort_idle: busy=%b done=%b, expected 0 0", busy_a, done_a);
    end
    mode_a = 0;
    run_a("pre_done", -1, -1);
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    tests++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0) begin
      fails++;
      $display("FAIL start_abort_done: busy=%b done=%b pass=%b, expected 0 0 0",
               busy_a, done_a, pass_a);
    end
  endtask

  task automatic test_reset_mid();
    mode_a = 1;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (18) @(negedge clk);
    tests++;
    if (vec_a !== 3'd6) begin
      fails++;
      $display("FAIL reset_mid_pos: vec=%0d, expected 6", vec_a);
    end
    rst_n_a = 1'b0;
    @(negedge clk);
    rst_n_a = 1'b1;
    tests++;
    if ({vec_a, busy_a, done_a, pass_a, err_a, fidx_a, fval_a} !== '0) begin
      fails++;
      $display("FAIL reset_mid: vec=%0d busy=%b done=%b pass=%b err=%0d fidx=%0d fval=%b, expected all 0",
               vec_a, busy_a, done_a, pass_a, err_a, fidx_a, fval_a);
    end
    mode_a = 0;
    run_a("after_reset", -1, -1);
  endtask

  task automatic test_and4();
    mode_b = 0; run_b("and4_correct");
    mode_b = 1; run_b("and4_tied1");
  endtask

  initial begin
    test_reset();
    test_faults();
    test_random();
    test_abort();
    test_start_abort_same();
    test_reset_mid();
    test_and4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
